mem_access_seq: RTL and testbench
=================================

Name: mem_access_seq

Overview:
- Sequencer between the memory-address mux output (IorD_output) and the synchronous byte-addressed data memory.
- Control unit issues one load/store request at a time (word/half/byte); block runs the memory cycles and extracts/sign-extends read data.
- Performs read-modify-write for sub-word stores and flags misaligned accesses.
- Frees the control FSM from counting memory wait states.

Parameters:
- READ_LAT, 1, memory read latency in cycles (1..3); mem_rdata valid READ_LAT cycles after mem_addr is stable.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request strobe; sampled only in IDLE
- op_wr  in  1  0 = load, 1 = store
- size  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- load_signed  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
- addr  in  32  byte address, from IorD_output
- wdata  in  32  store data; sub-word stores use low bits
- rdata  out  32  load result, held until next load completes
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle completion pulse
- misaligned  out  1  one-cycle pulse alongside done on alignment fault
- mem_addr  out  32  word address {addr_q[31:2],2'b00}
- mem_wr  out  1  memory write enable, one cycle per store
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Reset (async, any state): state=IDLE; rdata, mem_addr, mem_wdata = 0; mem_wr, busy, done, misaligned = 0; wait counter = 0. A request in flight is dropped with no done.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr_q[1:0]; a half selects lanes by addr_q[1].
- States: IDLE, RD_WAIT, WRITE, DONE, FAULT.
- IDLE:
  - On start, register op_wr, size, load_signed, addr, wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) -> FAULT.
  - Word store -> WRITE.
  - Any other request -> RD_WAIT with counter=READ_LAT-1.
- RD_WAIT:
  - Counter decrements each cycle.
  - At 0, capture mem_rdata into internal word register.
  - Then go to WRITE for a sub-word store, else DONE.
- WRITE:
  - mem_wr=1 for exactly this cycle.
  - mem_wdata = wdata_q for a word store.
  - For a sub-word store, mem_wdata = captured word with the selected lane(s) replaced by wdata_q[7:0] or wdata_q[15:0].
  - Next state DONE.
- DONE: done=1; a load updates rdata on entry (extract + extend). Next state IDLE.
- FAULT:
  - done=1 and misaligned=1, no memory access, rdata unchanged. Next state IDLE.
- Latency from the start cycle T:
  - Load: done at T+READ_LAT+1.
  - Word store: done at T+2.
  - Sub-word store: done at T+READ_LAT+2.
  - Fault: done at T+1.
- Request handling:
  - start while busy is ignored (no queueing).
  - start in the DONE→IDLE return cycle is not seen; the earliest new request is the cycle after done.
  - busy deasserts in the same cycle done pulses.
- Outputs are registered. mem_addr holds the last value in IDLE, and mem_wr is never high outside WRITE.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
  - Defined: alignment check and FAULT state as above.
  - Undefined: FAULT state and misaligned logic are removed, and the misaligned output is tied 0. The lane-select bits that must be zero for the size (addr[0] for half, addr[1:0] for word) are forced to 0, so the access truncates to the aligned unit.

Decomposition:
- Shared package mem_pkg:
  - Size encodings (SZ_WORD, SZ_HALF, SZ_BYTE).
  - State encoding constants.
  - Default READ_LAT.
- One combinational sub-module, sub_word_lane, containing:
  - Store merge (word, lane select, size, new data -> merged word).
  - Load extract (word, lane select, size, signed -> 32-bit result).

Test Plan:
- Word load, READ_LAT=1, addr=0x0000_0010, mem word 0xDEAD_BEEF -> mem_addr=0x10, done at T+2, rdata=0xDEAD_BEEF, mem_wr never 1.
- Signed byte load, addr=0x13, word 0x80FF_1234 -> rdata=0xFFFF_FF80. The same access with load_signed=0 -> 0x0000_0080.
- Half store, addr=0x22, wdata=0x0000_ABCD, memory word at 0x20 = 0x1111_2222 -> single mem_wr pulse with mem_wdata=0xABCD_2222, done at T+READ_LAT+2.
- Misaligned word load, addr=0x06, with MEM_ALIGN_CHECK_EN:
  - done and misaligned both pulse at T+1, mem_wr=0, rdata unchanged.
  - With the macro undefined: word at 0x04 is read normally.
- Reset asserted during RD_WAIT with READ_LAT=3 -> all outputs 0 immediately, no done; a new request afterwards completes normally.
- start pulsed again while busy during a byte store -> exactly one mem_wr and one done; the second request is ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for mem_access_seq: access sizes, FSM states, default read latency
// and the registered request layout.
package mem_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD_WAIT = 3'd1;
   localparam logic [2:0] ST_WRITE   = 3'd2;
   localparam logic [2:0] ST_DONE    = 3'd3;
   localparam logic [2:0] ST_FAULT   = 3'd4;

   localparam int READ_LAT_DEFAULT = 1;

   typedef struct packed {
      logic        op_wr;
      logic [1:0]  size;
      logic        load_signed;
      logic [1:0]  lane;
      logic [31:0] wdata;
   } req_t;

   // The reserved size code behaves exactly like a word access.
   function automatic logic is_word(input logic [1:0] size);
      return (size == SZ_WORD) || (size == SZ_RSVD);
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      if (is_word(size))
         bad = (lo != 2'b00);
      else if (size == SZ_HALF)
         bad = lo[0];
      return bad;
   endfunction

   function automatic logic [31:0] align_addr(input logic [1:0] size, input logic [31:0] addr);
      logic [31:0] a;
      a = addr;
      if (is_word(size))
         a[1:0] = 2'b00;
      else if (size == SZ_HALF)
         a[0] = 1'b0;
      return a;
   endfunction

endpackage

// File: rtl/sub_word_lane.sv
// Little-endian byte-lane logic: merges store data into a memory word and extracts
// (sign- or zero-extended) load data from it.
module sub_word_lane
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic [31:0] new_data,
   input  logic        load_signed,
   output logic [31:0] merged,
   output logic [31:0] extracted
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic       hit;
         logic [7:0] src;
         always_comb begin
            hit = 1'b0;
            src = new_data[8*gi +: 8];
            if (size == SZ_BYTE) begin
               hit = (lane == LANE);
               src = new_data[7:0];
            end else if (size == SZ_HALF) begin
               hit = (lane[1] == LANE[1]);
               src = LANE[0] ? new_data[15:8] : new_data[7:0];
            end else begin
               hit = 1'b1;
            end
         end
         assign merged[8*gi +: 8] = hit ? src : word[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      byte_sel  = word[{lane, 3'b000} +: 8];
      half_sel  = lane[1] ? word[31:16] : word[15:0];
      extracted = word;
      if (size == SZ_BYTE)
         extracted = {{24{load_signed & byte_sel[7]}}, byte_sel};
      else if (size == SZ_HALF)
         extracted = {{16{load_signed & half_sel[15]}}, half_sel};
   end

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer in front of a synchronous byte-addressed data memory.
// Build option MEM_ALIGN_CHECK_EN: alignment faults; otherwise misaligned addresses truncate.
module mem_access_seq
   import mem_pkg::*;
#(
   parameter int READ_LAT = READ_LAT_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op_wr,
   input  logic [1:0]  size,
   input  logic        load_signed,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        misaligned,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   logic [2:0]  state_reg;
   logic [1:0]  cnt_reg;
   req_t        req_q;
   logic [31:0] addr_eff;
   logic [31:0] merged;
   logic [31:0] extracted;

`ifdef MEM_ALIGN_CHECK_EN
   logic misaligned_reg;
   assign misaligned = misaligned_reg;
   assign addr_eff   = addr;
`else
   assign misaligned = 1'b0;
   assign addr_eff   = align_addr(size, addr);
`endif

   // Merge and extract both work on the live memory word in the capture cycle.
   sub_word_lane u_lane (
      .word        (mem_rdata),
      .lane        (req_q.lane),
      .size        (req_q.size),
      .new_data    (req_q.wdata),
      .load_signed (req_q.load_signed),
      .merged      (merged),
      .extracted   (extracted)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= 2'd0;
         req_q          <= '0;
         rdata          <= 32'd0;
         mem_addr       <= 32'd0;
         mem_wdata      <= 32'd0;
         mem_wr         <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         misaligned_reg <= 1'b0;
`endif
      end else begin
         done   <= 1'b0;
         mem_wr <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         misaligned_reg <= 1'b0;
`endif
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  req_q.op_wr       <= op_wr;
                  req_q.size        <= size;
                  req_q.load_signed <= load_signed;
                  req_q.lane        <= addr_eff[1:0];
                  req_q.wdata       <= wdata;
`ifdef MEM_ALIGN_CHECK_EN
                  if (is_misaligned(size, addr[1:0])) begin
                     state_reg      <= ST_FAULT;
                     done           <= 1'b1;
                     misaligned_reg <= 1'b1;
                  end else
`endif
                  begin
                     mem_addr <= {addr_eff[31:2], 2'b00};
                     busy     <= 1'b1;
                     if (op_wr && is_word(size)) begin
                        state_reg <= ST_WRITE;
                        mem_wr    <= 1'b1;
                        mem_wdata <= wdata;
                     end else begin
                        state_reg <= ST_RD_WAIT;
                        cnt_reg   <= 2'(READ_LAT - 1);
                     end
                  end
               end
            end
            ST_RD_WAIT: begin
               if (cnt_reg == 2'd0) begin
                  if (req_q.op_wr) begin
                     state_reg <= ST_WRITE;
                     mem_wr    <= 1'b1;
                     mem_wdata <= merged;
                  end else begin
                     state_reg <= ST_DONE;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     rdata     <= extracted;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 2'd1;
               end
            end
            ST_WRITE: begin
               state_reg <= ST_DONE;
               done      <= 1'b1;
               busy      <= 1'b0;
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
            end
`ifdef MEM_ALIGN_CHECK_EN
            ST_FAULT: begin
               state_reg <= ST_IDLE;
            end
`endif
            default: begin
               state_reg <= ST_IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: two instances (READ_LAT 1 and 3) share stimulus,
// each with its own memory model and an independent done-driven checker.
`timescale 1ns/1ps
module tb_mem_access_seq;
   import mem_pkg::*;

   localparam int RL0 = 1;
   localparam int RL1 = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start, op_wr, load_signed;
   logic [1:0]  size;
   logic [31:0] addr, wdata;

   logic [31:0] rdata [2];
   logic [31:0] mem_addr [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic        busy [2];
   logic        done [2];
   logic        misaligned [2];
   logic        mem_wr [2];

   mem_access_seq #(.READ_LAT(RL0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .op_wr(op_wr), .size(size),
      .load_signed(load_signed), .addr(addr), .wdata(wdata), .rdata(rdata[0]),
      .busy(busy[0]), .done(done[0]), .misaligned(misaligned[0]), .mem_addr(mem_addr[0]),
      .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
   );

   mem_access_seq #(.READ_LAT(RL1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .op_wr(op_wr), .size(size),
      .load_signed(load_signed), .addr(addr), .wdata(wdata), .rdata(rdata[1]),
      .busy(busy[1]), .done(done[1]), .misaligned(misaligned[1]), .mem_addr(mem_addr[1]),
      .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
   );

   // Memory models: READ_LAT=1 reads combinationally, READ_LAT=3 through two registers.
   logic [31:0] mem0 [0:63];
   logic [31:0] mem1 [0:63];
   logic [31:0] pipe_a, pipe_b;
   logic        init_en = 1'b0;
   logic [5:0]  init_idx;
   logic [31:0] init_val;

   assign mem_rdata[0] = mem0[mem_addr[0][7:2]];
   assign mem_rdata[1] = pipe_b;

   always @(posedge clk) begin
      if (init_en) begin
         mem0[init_idx] <= init_val;
         mem1[init_idx] <= init_val;
      end
      if (mem_wr[0]) mem0[mem_addr[0][7:2]] <= mem_wdata[0];
      if (mem_wr[1]) mem1[mem_addr[1][7:2]] <= mem_wdata[1];
      pipe_a <= mem1[mem_addr[1][7:2]];
      pipe_b <= pipe_a;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          start_cyc;
      int          lat0;
      int          lat1;
      logic [31:0] rdata;
      logic        mis;
      int          n_wr;
      logic [31:0] wdata;
      logic [31:0] maddr;
   } exp_t;

   exp_t        exp_q [$];
   int          rd_idx [2];
   int          wr_cnt [2];
   logic [31:0] wr_seen [2];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] prev_rdata = 32'd0;
   logic [31:0] prev_maddr = 32'd0;

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s dut%0d got %h expected %h", name, k, act, expv);
      end
   endtask

   // Monitor: one transaction completes per done pulse.
   exp_t e_mon;
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            wr_cnt[k] = 0;
         end else begin
            if (mem_wr[k]) begin
               wr_cnt[k]++;
               wr_seen[k] = mem_wdata[k];
            end
            if (done[k]) begin
               if (rd_idx[k] >= exp_q.size()) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done dut%0d got done=1 expected no done", k);
               end else begin
                  e_mon = exp_q[rd_idx[k]];
                  rd_idx[k]++;
                  chk("latency", k, cyc - e_mon.start_cyc, (k == 0) ? e_mon.lat0 : e_mon.lat1);
                  chk("rdata", k, rdata[k], e_mon.rdata);
                  chk("misaligned", k, {31'd0, misaligned[k]}, {31'd0, e_mon.mis});
                  chk("mem_wr_count", k, wr_cnt[k], e_mon.n_wr);
                  if (e_mon.n_wr > 0) chk("mem_wdata", k, wr_seen[k], e_mon.wdata);
                  chk("mem_addr", k, mem_addr[k], e_mon.maddr);
                  chk("busy_at_done", k, {31'd0, busy[k]}, 32'd0);
               end
               wr_cnt[k] = 0;
            end
         end
      end
   end

   task automatic set_word(input logic [31:0] a, input logic [31:0] v);
      @(posedge clk); #1;
      init_en = 1'b1; init_idx = a[7:2]; init_val = v;
      @(posedge clk); #1;
      init_en = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk({tag, "_rdata"}, k, rdata[k], 32'd0);
         chk({tag, "_mem_addr"}, k, mem_addr[k], 32'd0);
         chk({tag, "_mem_wdata"}, k, mem_wdata[k], 32'd0);
         chk({tag, "_ctl"}, k, {28'd0, busy[k], done[k], misaligned[k], mem_wr[k]}, 32'd0);
      end
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic fault,
                        input logic [31:0] exp_wd, input logic [31:0] exp_ma, input logic resend);
      exp_t e;
      bit   drained;
      @(posedge clk); #1;
      start = 1'b1; op_wr = w; size = sz; load_signed = sg; addr = a; wdata = wd;
      e.start_cyc = cyc;
      e.mis   = fault;
      e.wdata = exp_wd;
      e.rdata = prev_rdata;
      e.maddr = prev_maddr;
      if (fault) begin
         e.lat0 = 1; e.lat1 = 1; e.n_wr = 0;
      end else begin
         e.maddr = exp_ma;
         prev_maddr = exp_ma;
         if (!w) begin
            e.lat0 = RL0 + 1; e.lat1 = RL1 + 1; e.n_wr = 0;
            e.rdata = exp_rd;
            prev_rdata = exp_rd;
         end else if (sz == SZ_WORD) begin
            e.lat0 = 2; e.lat1 = 2; e.n_wr = 1;
         end else begin
            e.lat0 = RL0 + 2; e.lat1 = RL1 + 2; e.n_wr = 1;
         end
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (resend) begin
         chk("busy_in_flight", 0, {31'd0, busy[0]}, 32'd1);
         chk("busy_in_flight", 1, {31'd0, busy[1]}, 32'd1);
         start = 1'b1; op_wr = 1'b0; addr = 32'h0000_0040;
         @(posedge clk); #1;
      end
      start = 1'b0;
      drained = 1'b0;
      for (int i = 0; i < 30 && !drained; i++) begin
         @(posedge clk);
         drained = (rd_idx[0] == exp_q.size()) && (rd_idx[1] == exp_q.size());
      end
      if (!drained) begin
         checks++;
         errors++;
         $display("FAIL done_timeout got no done expected done within 30 cycles addr %h", a);
         rd_idx[0] = exp_q.size();
         rd_idx[1] = exp_q.size();
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op_wr = 1'b0; size = SZ_WORD; load_signed = 1'b0;
      addr = 32'd0; wdata = 32'd0;
      rd_idx[0] = 0; rd_idx[1] = 0; wr_cnt[0] = 0; wr_cnt[1] = 0;
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      set_word(32'h10, 32'hDEAD_BEEF);
      set_word(32'h20, 32'h1111_2222);
      set_word(32'h30, 32'h4433_2211);
      set_word(32'h04, 32'h0BAD_F00D);

      // w, size, signed, addr, wdata, exp_rdata, fault, exp_wdata, exp_maddr, resend
      issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h10, 1'b0);
      set_word(32'h10, 32'h80FF_1234);
      issue(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 32'h0, 32'h10, 1'b0);
      issue(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 32'h0, 32'h10, 1'b0);
      issue(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000_ABCD, 32'h0, 1'b0, 32'hABCD_2222, 32'h20, 1'b0);
      issue(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'hFFFF_ABCD, 1'b0, 32'h0, 32'h20, 1'b0);
      issue(1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 32'h0000_2222, 1'b0, 32'h0, 32'h20, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
      issue(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
      issue(1'b0, SZ_HALF, 1'b0, 32'h23, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
`else
      issue(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 32'h0BAD_F00D, 1'b0, 32'h0, 32'h04, 1'b0);
      issue(1'b0, SZ_HALF, 1'b0, 32'h23, 32'h0, 32'h0000_ABCD, 1'b0, 32'h0, 32'h20, 1'b0);
`endif
      issue(1'b1, SZ_BYTE, 1'b0, 32'h31, 32'h0000_00A5, 32'h0, 1'b0, 32'h4433_A511, 32'h30, 1'b1);
      issue(1'b0, SZ_BYTE, 1'b1, 32'h31, 32'h0, 32'hFFFF_FFA5, 1'b0, 32'h0, 32'h30, 1'b0);
      issue(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 32'h4433_A511, 1'b0, 32'h0, 32'h30, 1'b0);
      issue(1'b1, SZ_WORD, 1'b0, 32'h50, 32'h1234_5678, 32'h0, 1'b0, 32'h1234_5678, 32'h50, 1'b0);
      issue(1'b0, SZ_RSVD, 1'b1, 32'h50, 32'h0, 32'h1234_5678, 1'b0, 32'h0, 32'h50, 1'b0);

      // Reset while both instances sit in RD_WAIT: request dropped, no done.
      @(posedge clk); #1;
      start = 1'b1; op_wr = 1'b0; size = SZ_WORD; addr = 32'h10;
      @(posedge clk); #1;
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check_zero("reset_in_flight");
      @(posedge clk); #1;
      reset = 1'b0;
      prev_rdata = 32'd0;
      prev_maddr = 32'd0;
      repeat (6) @(posedge clk);
      issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h80FF_1234, 1'b0, 32'h0, 32'h10, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running expected finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
